apb_slave_mem: RTL and testbench

APB_SLAVE_MEM -- requirements
Module: apb_slave_mem

---
 rtl/apb_slave_mem_if.sv | 21 ++
 rtl/apb_slave_mem.sv | 133 +++++++++++++
 tb/tb_apb_slave_mem.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_slave_mem_if.sv
// APB3-style bus bundle between a bridge (master) and the apb_slave_mem block (slave).
interface apb_slave_mem_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_slave_mem.sv
// APB slave backed by a 64 x 32-bit register file in a 256-byte window at BASE_ADDR,
// with a programmable number of wait states and a completed-transfer counter.
module apb_slave_mem #(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst,
    apb_slave_mem_if.slave  bus,
    output logic [15:0]     xfer_cnt,
    output logic            fsm_state
);
    // Handshake: a transfer is a setup cycle (psel=1, penable=0) followed by access
    // cycles (psel=1, penable=1); it completes on the edge where psel, penable and
    // pready are all 1. Dropping psel before that edge aborts the transfer.
    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic [5:0]  idx_q, idx_nx;
    logic        hit_q, hit_nx;
    logic        write_q, write_nx;
    logic [31:0] wdata_q, wdata_nx;
    logic        ready_q, ready_nx;
    logic        err_q, err_nx;
    logic [31:0] rdata_q, rdata_nx;
    logic [15:0] xfer_cnt_nx;
    logic        mem_we;
    logic [31:0] mem [64];

    logic setup_hit;
    logic unused_addr_bits;

    assign setup_hit        = (bus.paddr[31:8] == BASE_ADDR[31:8]);
    assign unused_addr_bits = ^bus.paddr[1:0];

    assign bus.pready  = ready_q;
    assign bus.pslverr = err_q;
    assign bus.prdata  = rdata_q;
    assign fsm_state   = state;

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        idx_nx      = idx_q;
        hit_nx      = hit_q;
        write_nx    = write_q;
        wdata_nx    = wdata_q;
        ready_nx    = ready_q;
        err_nx      = err_q;
        rdata_nx    = rdata_q;
        xfer_cnt_nx = xfer_cnt;
        mem_we      = 1'b0;

        case (state)
            IDLE: begin
                ready_nx = 1'b0;
                err_nx   = 1'b0;
                rdata_nx = '0;
                if (bus.psel && !bus.penable) begin
                    state_nx = ACCESS;
                    idx_nx   = bus.paddr[7:2];
                    hit_nx   = setup_hit;
                    write_nx = bus.pwrite;
                    wdata_nx = bus.pwdata;
                    cnt_nx   = WAIT_LD;
                    // Zero wait states: the response is built from the live bus fields.
                    if (WAIT_LD == 4'd0) begin
                        ready_nx = 1'b1;
                        err_nx   = !setup_hit;
                        rdata_nx = (!bus.pwrite && setup_hit) ? mem[bus.paddr[7:2]] : '0;
                    end
                end
            end
            ACCESS: begin
                if (!bus.psel) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                    ready_nx = 1'b0;
                    err_nx   = 1'b0;
                    rdata_nx = '0;
                end else if (ready_q) begin
                    if (bus.penable) begin
                        mem_we      = write_q && hit_q;
                        xfer_cnt_nx = xfer_cnt + 16'd1;
                        state_nx    = IDLE;
                        ready_nx    = 1'b0;
                        err_nx      = 1'b0;
                        rdata_nx    = '0;
                    end
                end else if (cnt <= 4'd1) begin
                    cnt_nx   = '0;
                    ready_nx = 1'b1;
                    err_nx   = !hit_q;
                    rdata_nx = (!write_q && hit_q) ? mem[idx_q] : '0;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            idx_q    <= '0;
            hit_q    <= 1'b0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            xfer_cnt <= '0;
            for (int i = 0; i < 64; i++) mem[i] <= '0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            idx_q    <= idx_nx;
            hit_q    <= hit_nx;
            write_q  <= write_nx;
            wdata_q  <= wdata_nx;
            ready_q  <= ready_nx;
            err_q    <= err_nx;
            rdata_q  <= rdata_nx;
            xfer_cnt <= xfer_cnt_nx;
            if (mem_we) mem[idx_q] <= wdata_q;
        end
    end
endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: three instances (1, 0 and 3 wait states) share one bus driver,
// with psel steered to the instance under test; results are checked against an array model.
module tb_apb_slave_mem;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int WAITS [3] = '{1, 0, 3};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    int          sel;

    logic        pready, pslverr, fsm_state;
    logic [31:0] prdata;
    logic [15:0] xfer_cnt;

    apb_slave_mem_if bus0 ();
    apb_slave_mem_if bus1 ();
    apb_slave_mem_if bus2 ();
    logic [15:0] cnt0, cnt1, cnt2;
    logic        st0, st1, st2;

    assign bus0.psel = psel && (sel == 0);
    assign bus1.psel = psel && (sel == 1);
    assign bus2.psel = psel && (sel == 2);
    assign bus0.penable = penable;
    assign bus1.penable = penable;
    assign bus2.penable = penable;
    assign bus0.pwrite = pwrite;
    assign bus1.pwrite = pwrite;
    assign bus2.pwrite = pwrite;
    assign bus0.paddr = paddr;
    assign bus1.paddr = paddr;
    assign bus2.paddr = paddr;
    assign bus0.pwdata = pwdata;
    assign bus1.pwdata = pwdata;
    assign bus2.pwdata = pwdata;

    apb_slave_mem #(.BASE_ADDR(BASE), .WAIT_CYCLES(WAITS[0])) u_w1 (
        .clk(clk), .rst(rst), .bus(bus0), .xfer_cnt(cnt0), .fsm_state(st0));
    apb_slave_mem #(.BASE_ADDR(BASE), .WAIT_CYCLES(WAITS[1])) u_w0 (
        .clk(clk), .rst(rst), .bus(bus1), .xfer_cnt(cnt1), .fsm_state(st1));
    apb_slave_mem #(.BASE_ADDR(BASE), .WAIT_CYCLES(WAITS[2])) u_w3 (
        .clk(clk), .rst(rst), .bus(bus2), .xfer_cnt(cnt2), .fsm_state(st2));

    always_comb begin
        case (sel)
            1: begin
                pready = bus1.pready; pslverr = bus1.pslverr; prdata = bus1.prdata;
                xfer_cnt = cnt1; fsm_state = st1;
            end
            2: begin
                pready = bus2.pready; pslverr = bus2.pslverr; prdata = bus2.prdata;
                xfer_cnt = cnt2; fsm_state = st2;
            end
            default: begin
                pready = bus0.pready; pslverr = bus0.pslverr; prdata = bus0.prdata;
                xfer_cnt = cnt0; fsm_state = st0;
            end
        endcase
    end

    // Reference model: per-instance word array and completed-transfer count.
    logic [31:0] ref_mem [3][64];
    logic [15:0] ref_cnt [3];
    logic [31:0] exp_q [$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (sel=%0d t=%0t)", tag, got, exp, sel, $time);
        end
    endtask

    function automatic logic is_hit(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'd256);
    endfunction

    function automatic logic [5:0] word_of(input logic [31:0] a);
        logic [31:0] off;
        off = (a - BASE) / 4;
        return off[5:0];
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 3; s++) begin
            ref_cnt[s] = '0;
            for (int w = 0; w < 64; w++) ref_mem[s][w] = '0;
        end
    endtask

    // Full transfer: setup, then access cycles until pready; completion is on the next edge.
    task automatic do_xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                           input string tag);
        int k;
        logic exp_err;
        exp_err = !is_hit(a);
        exp_q.push_back((!wr && is_hit(a)) ? ref_mem[sel][word_of(a)] : 32'h0);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(negedge clk);
        penable = 1'b1;
        k = 1;
        while (pready !== 1'b1 && k < 24) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_lat"}, 32'(k), 32'(WAITS[sel] + 1));
        check({tag, "_rdata"}, prdata, exp_q.pop_front());
        check({tag, "_err"}, 32'(pslverr), 32'(exp_err));
        if (wr && is_hit(a)) ref_mem[sel][word_of(a)] = d;
        ref_cnt[sel] = ref_cnt[sel] + 16'd1;
    endtask

    task automatic end_idle(input int n, input string tag);
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
        check({tag, "_idle_rdy"}, 32'(pready), 32'h0);
        check({tag, "_idle_cnt"}, 32'(xfer_cnt), 32'(ref_cnt[sel]));
        check({tag, "_idle_st"}, 32'(fsm_state), 32'h0);
        repeat (n) @(negedge clk);
    endtask

    // Setup plus n_acc access cycles (all before pready can rise), then psel drops.
    task automatic do_abort(input logic wr, input logic [31:0] a, input logic [31:0] d,
                            input int n_acc, input string tag);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        for (int i = 0; i < n_acc; i++) begin
            @(negedge clk);
            penable = 1'b1;
            check({tag, "_wait_rdy"}, 32'(pready), 32'h0);
        end
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        check({tag, "_ab_rdy"}, 32'(pready), 32'h0);
        check({tag, "_ab_err"}, 32'(pslverr), 32'h0);
        check({tag, "_ab_rdata"}, prdata, 32'h0);
        check({tag, "_ab_cnt"}, 32'(xfer_cnt), 32'(ref_cnt[sel]));
    endtask

    initial begin
        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; sel = 0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check("rst_rdy", 32'(pready), 32'h0);
            check("rst_rdata", prdata, 32'h0);
            check("rst_cnt", 32'(xfer_cnt), 32'h0);
        end
        sel = 0;

        // One wait state: write then read the same word, byte offset ignored.
        do_xfer(1'b1, 32'h8000_0001, 32'hA300_1111, "w1_wr");
        do_xfer(1'b0, 32'h8000_0000, 32'h0, "w1_rd");
        end_idle(1, "w1");
        check("w1_cnt2", 32'(xfer_cnt), 32'd2);
        do_xfer(1'b0, 32'h8000_00A2, 32'h0, "w1_rd_a2");
        end_idle(0, "w1b");
        // Write miss leaves memory unchanged.
        do_xfer(1'b1, 32'h9000_0010, 32'hDEAD_BEEF, "miss_wr");
        do_xfer(1'b0, 32'h8000_0010, 32'h0, "miss_rd");
        // Access-phase signalling with no setup is ignored.
        @(negedge clk);
        psel = 1'b1; penable = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("no_setup_rdy", 32'(pready), 32'h0);
        end
        end_idle(0, "no_setup");

        // Zero wait states, back-to-back write then read.
        sel = 1;
        do_xfer(1'b1, 32'h8000_00FC, 32'h1234_5678, "w0_wr");
        do_xfer(1'b0, 32'h8000_00FC, 32'h0, "w0_rd");
        end_idle(0, "w0");

        // Three wait states: abort after one access cycle.
        sel = 2;
        do_abort(1'b1, 32'h8000_0020, 32'h5555_AAAA, 1, "ab3");
        do_xfer(1'b0, 32'h8000_0020, 32'h0, "ab3_rd");
        end_idle(0, "ab3");

        // Reset during the wait state of a write.
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h8000_0040; pwdata = 32'hCAFE_0040;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check("rst_mid_rdy", 32'(pready), 32'h0);
        check("rst_mid_err", 32'(pslverr), 32'h0);
        check("rst_mid_rdata", prdata, 32'h0);
        check("rst_mid_cnt", 32'(xfer_cnt), 32'h0);
        repeat (5) begin
            @(negedge clk);
            check("rst_stale_rdy", 32'(pready), 32'h0);
        end
        end_idle(0, "rst_mid");
        do_xfer(1'b0, 32'h8000_0040, 32'h0, "rst_rd");
        end_idle(0, "rst_rd");

        // Randomized traffic on each instance.
        for (int s = 0; s < 3; s++) begin
            sel = s;
            for (int n = 0; n < 60; n++) begin
                logic [31:0] a;
                logic        wr;
                wr = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 9) < 8) begin
                    a = BASE + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
                end else begin
                    a = $urandom;
                    if (is_hit(a)) a = a ^ 32'h4000_0000;
                end
                if (WAITS[s] > 0 && $urandom_range(0, 9) == 0) begin
                    do_abort(wr, a, $urandom, $urandom_range(1, WAITS[s]), "rnd_ab");
                end else begin
                    do_xfer(wr, a, $urandom, "rnd");
                    if ($urandom_range(0, 2) == 0) end_idle($urandom_range(0, 2), "rnd");
                end
            end
            end_idle(0, "rnd_end");
        end

        check("exp_q_empty", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
